// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, branch flush and
// multi-cycle mul/div hold, with a saturating count of stalled cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; load-use, branch and mul/div start are decoded
// LU_STALL | one-cycle recovery after a load-use bubble; no hazard decode
// MD_BUSY  | mul/div in flight; front end and EX/MEM frozen until cnt = 0
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RtAddr_i,
    input  logic [4:0]  IFID_RsAddr_i,
    input  logic [4:0]  IFID_RtAddr_i,
    input  logic        Branch_taken_i,
    input  logic        MulDiv_start_i,
    input  logic        MulDiv_div_i,
    output logic        PC_write_o,
    output logic        IFID_write_o,
    output logic        IDEX_bubble_o,
    output logic        IFID_flush_o,
    output logic        Pipe_hold_o,
    output logic        MulDiv_done_o,
    output logic [15:0] Stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    // Counter is loaded with N-1 so the final hold cycle is the one at cnt = 0.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;
    logic        w_lu;

    assign w_lu = (r_state == RUN) && IDEX_MemRead_i && (IDEX_RtAddr_i != 5'd0) &&
                  ((IDEX_RtAddr_i == IFID_RsAddr_i) || (IDEX_RtAddr_i == IFID_RtAddr_i));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IDEX_bubble_o = 1'b0;
        IFID_flush_o  = 1'b0;
        Pipe_hold_o   = 1'b0;
        MulDiv_done_o = 1'b0;

        case (r_state)
            RUN: begin
                // A pending load-use holds the branch; it re-resolves after the bubble.
                IFID_flush_o = Branch_taken_i && !w_lu;
                if (MulDiv_start_i) begin
                    w_cnt_nxt   = MulDiv_div_i ? DIV_LOAD : MUL_LOAD;
                    w_state_nxt = MD_BUSY;
                end else if (w_lu) begin
                    PC_write_o    = 1'b0;
                    IFID_write_o  = 1'b0;
                    IDEX_bubble_o = 1'b1;
                    w_state_nxt   = LU_STALL;
                end
            end
            LU_STALL: begin
                IFID_flush_o = Branch_taken_i;
                w_state_nxt  = RUN;
            end
            MD_BUSY: begin
                PC_write_o   = 1'b0;
                IFID_write_o = 1'b0;
                Pipe_hold_o  = 1'b1;
                if (r_cnt == 6'd0) begin
                    MulDiv_done_o = 1'b1;
                    w_state_nxt   = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 6'd0;
            end
        endcase

        if (rst_i) begin
            w_state_nxt   = RUN;
            w_cnt_nxt     = 6'd0;
            PC_write_o    = 1'b1;
            IFID_write_o  = 1'b1;
            IDEX_bubble_o = 1'b0;
            IFID_flush_o  = 1'b0;
            Pipe_hold_o   = 1'b0;
            MulDiv_done_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_cnt       <= 6'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!PC_write_o && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign Stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle decode vectors
// plus hand-written multi-cycle sequences for mul/div hold, reset abort and branch.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RtAddr_i;
    logic [4:0]  IFID_RsAddr_i;
    logic [4:0]  IFID_RtAddr_i;
    logic        Branch_taken_i;
    logic        MulDiv_start_i;
    logic        MulDiv_div_i;
    logic        PC_write_o;
    logic        IFID_write_o;
    logic        IDEX_bubble_o;
    logic        IFID_flush_o;
    logic        Pipe_hold_o;
    logic        MulDiv_done_o;
    logic [15:0] Stall_cnt_o;

    hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_RtAddr_i  (IDEX_RtAddr_i),
        .IFID_RsAddr_i  (IFID_RsAddr_i),
        .IFID_RtAddr_i  (IFID_RtAddr_i),
        .Branch_taken_i (Branch_taken_i),
        .MulDiv_start_i (MulDiv_start_i),
        .MulDiv_div_i   (MulDiv_div_i),
        .PC_write_o     (PC_write_o),
        .IFID_write_o   (IFID_write_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .IFID_flush_o   (IFID_flush_o),
        .Pipe_hold_o    (Pipe_hold_o),
        .MulDiv_done_o  (MulDiv_done_o),
        .Stall_cnt_o    (Stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Output bundle order: {pc_write, ifid_write, bubble, flush, hold, done}
    localparam logic [5:0] O_NORM  = 6'b110000;
    localparam logic [5:0] O_LU    = 6'b001000;
    localparam logic [5:0] O_FLUSH = 6'b110100;

    typedef struct {
        logic        mr;
        logic [4:0]  ex_rt;
        logic [4:0]  id_rs;
        logic [4:0]  id_rt;
        logic        br;
        logic        st;
        logic        dv;
        logic [5:0]  exp_out;
        logic        exp_nxt_pc;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t       vecs[13];
    logic [5:0] exp_q[$];
    logic [5:0] obs;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign obs = {PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o, Pipe_hold_o, MulDiv_done_o};

    function automatic vec_t mk(input logic mr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                                input logic [4:0] id_rt, input logic br, input logic st, input logic dv,
                                input logic [5:0] eo, input logic enp, input logic [15:0] es);
        vec_t v;
        v.mr = mr; v.ex_rt = ex_rt; v.id_rs = id_rs; v.id_rt = id_rt;
        v.br = br; v.st = st; v.dv = dv;
        v.exp_out = eo; v.exp_nxt_pc = enp; v.exp_stall = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [5:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", name, obs);
        end else begin
            e = exp_q.pop_front();
            chk(name, {26'd0, obs}, {26'd0, e});
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                         input logic [4:0] id_rt, input logic br, input logic st, input logic dv);
        IDEX_MemRead_i = mr;
        IDEX_RtAddr_i  = ex_rt;
        IFID_RsAddr_i  = id_rs;
        IFID_RtAddr_i  = id_rt;
        Branch_taken_i = br;
        MulDiv_start_i = st;
        MulDiv_div_i   = dv;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    // Issues one mul/div, re-asserts start and branch inside the hold window,
    // and measures the hold length, done position and stall increment.
    task automatic md_seq(input logic dv, input int n_exp, input string tag);
        int hold_n = 0;
        int done_n = 0;
        int done_at = 0;
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, dv);
        expect_out(O_NORM);
        #3;
        check_out({tag, "_start_out"});
        next_cycle();
        for (int c = 0; c < 100; c++) begin
            if (c == 1) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, ~dv);
            else        idle();
            #3;
            if (!Pipe_hold_o) break;
            hold_n++;
            if (MulDiv_done_o) begin
                done_n++;
                done_at = hold_n;
            end
            if (c == 1) chk({tag, "_flush_in_busy"}, {31'd0, IFID_flush_o}, 32'd0);
            next_cycle();
        end
        chk({tag, "_hold_len"}, hold_n, n_exp);
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_done_pos"}, done_at, n_exp);
        chk({tag, "_stall"}, {16'd0, Stall_cnt_o}, n_exp);
        chk({tag, "_pc_after"}, {31'd0, PC_write_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM,  1'b1, 16'd0);
        vecs[1]  = mk(1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, O_LU,    1'b1, 16'd1);
        vecs[2]  = mk(1'b1, 5'd7,  5'd3, 5'd7,  1'b0, 1'b0, 1'b0, O_LU,    1'b1, 16'd1);
        vecs[3]  = mk(1'b1, 5'd7,  5'd3, 5'd4,  1'b0, 1'b0, 1'b0, O_NORM,  1'b1, 16'd0);
        vecs[4]  = mk(1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM,  1'b1, 16'd0);
        vecs[5]  = mk(1'b0, 5'd5,  5'd5, 5'd5,  1'b0, 1'b0, 1'b0, O_NORM,  1'b1, 16'd0);
        vecs[6]  = mk(1'b0, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, O_FLUSH, 1'b1, 16'd0);
        vecs[7]  = mk(1'b1, 5'd5,  5'd5, 5'd0,  1'b1, 1'b0, 1'b0, O_LU,    1'b1, 16'd1);
        vecs[8]  = mk(1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, O_NORM,  1'b0, 16'd0);
        vecs[9]  = mk(1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b1, 1'b0, O_NORM,  1'b0, 16'd0);
        vecs[10] = mk(1'b0, 5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b1, O_FLUSH, 1'b0, 16'd0);
        vecs[11] = mk(1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, O_LU,    1'b1, 16'd1);
        vecs[12] = mk(1'b1, 5'd0,  5'd9, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM,  1'b1, 16'd0);

        rst_i = 1'b1;
        idle();
        next_cycle();

        foreach (vecs[i]) begin
            // Reset cycle with the vector already applied: outputs must stay neutral.
            rst_i = 1'b1;
            drive(vecs[i].mr, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
                  vecs[i].br, vecs[i].st, vecs[i].dv);
            expect_out(O_NORM);
            #3;
            check_out($sformatf("v%0d_rst_out", i));
            next_cycle();
            rst_i = 1'b0;
            chk($sformatf("v%0d_rst_stall", i), {16'd0, Stall_cnt_o}, 32'd0);
            expect_out(vecs[i].exp_out);
            #3;
            check_out($sformatf("v%0d_out", i));
            next_cycle();
            idle();
            #3;
            chk($sformatf("v%0d_nxt_pc", i), {31'd0, PC_write_o}, {31'd0, vecs[i].exp_nxt_pc});
            chk($sformatf("v%0d_stall", i), {16'd0, Stall_cnt_o}, {16'd0, vecs[i].exp_stall});
            next_cycle();
        end

        md_seq(1'b0, 4, "mul");
        md_seq(1'b1, 32, "div");

        // Reset arriving in the 11th hold cycle of a divide.
        begin
            int done_n = 0;
            do_reset();
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
            next_cycle();
            idle();
            for (int c = 0; c < 10; c++) begin
                #3;
                if (MulDiv_done_o) done_n++;
                next_cycle();
            end
            chk("rstdiv_hold_before", {31'd0, Pipe_hold_o}, 32'd1);
            rst_i = 1'b1;
            expect_out(O_NORM);
            #3;
            check_out("rstdiv_out_in_rst");
            next_cycle();
            rst_i = 1'b0;
            #3;
            if (MulDiv_done_o) done_n++;
            chk("rstdiv_hold_after", {31'd0, Pipe_hold_o}, 32'd0);
            chk("rstdiv_pc_after", {31'd0, PC_write_o}, 32'd1);
            chk("rstdiv_stall", {16'd0, Stall_cnt_o}, 32'd0);
            chk("rstdiv_no_done", done_n, 0);
            next_cycle();
        end

        // Branch together with load-use: flush deferred to the stall cycle.
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out(O_LU);
        #3;
        check_out("brlu_first");
        next_cycle();
        expect_out(O_FLUSH);
        #3;
        check_out("brlu_second");
        next_cycle();
        idle();
        #3;
        chk("brlu_pc_third", {31'd0, PC_write_o}, 32'd1);
        chk("brlu_stall", {16'd0, Stall_cnt_o}, 32'd1);
        next_cycle();

        // Reset during LU_STALL with a taken branch.
        do_reset();
        drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst_i = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_out(O_NORM);
        #3;
        check_out("rstlu_out");
        next_cycle();
        rst_i = 1'b0;
        idle();
        #3;
        chk("rstlu_stall", {16'd0, Stall_cnt_o}, 32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
